// File: rtl/itu656_ycbcr_decoder.sv
// BT.656 4:2:2 byte-stream decoder: timing-code tracking and
// per-pixel Y/Cb/Cr output with chroma shared across each pixel pair.
module itu656_ycbcr_decoder #(
    parameter int H_ACTIVE = 720,
    parameter int LINE_W   = 10
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [7:0]        iTD_DATA,
    output logic [7:0]        oY,
    output logic [7:0]        oCb,
    output logic [7:0]        oCr,
    output logic              oDVAL,
    output logic [9:0]        oX,
    output logic [LINE_W-1:0] oLine,
    output logic              oField,
    output logic              oVBLANK,
    output logic              oCodeErr
);

    localparam logic [0:0] ST_BLANK  = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [7:0]  BYTE_FF = 8'hFF;
    localparam logic [10:0] PIX_MAX = 11'(H_ACTIVE);

    logic [0:0]  state;
    logic [1:0]  phase;
    logic [10:0] pixCnt;
    logic [7:0]  win0, win1, win2;
    logic [7:0]  cbReg, y0Reg, crReg;
    logic        lineRst;

    logic preamble;
    logic xyF, xyV, xyH;
    logic xyOk;
    logic isFF;
    logic canEmit;

    assign preamble = (win0 == 8'hFF) && (win1 == 8'h00) && (win2 == 8'h00);
    assign xyF      = iTD_DATA[6];
    assign xyV      = iTD_DATA[5];
    assign xyH      = iTD_DATA[4];
    assign xyOk     = iTD_DATA[7] &&
                      (iTD_DATA[3:0] == {xyV ^ xyH, xyF ^ xyH,
                                         xyF ^ xyV, xyF ^ xyV ^ xyH});
    assign isFF     = (iTD_DATA == BYTE_FF);
    assign canEmit  = (pixCnt < PIX_MAX);

    // Window shifts in every state so a preamble is seen even mid-line.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            win0 <= 8'h00;
            win1 <= 8'h00;
            win2 <= 8'h00;
        end else begin
            win0 <= win1;
            win1 <= win2;
            win2 <= iTD_DATA;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= ST_BLANK;
            phase    <= 2'd0;
            pixCnt   <= '0;
            cbReg    <= 8'h00;
            y0Reg    <= 8'h00;
            crReg    <= 8'h00;
            lineRst  <= 1'b1;
            oY       <= 8'h00;
            oCb      <= 8'h00;
            oCr      <= 8'h00;
            oDVAL    <= 1'b0;
            oX       <= 10'd0;
            oLine    <= '0;
            oField   <= 1'b0;
            oVBLANK  <= 1'b0;
            oCodeErr <= 1'b0;
        end else begin
            oDVAL    <= 1'b0;
            oCodeErr <= 1'b0;
            if (preamble) begin
                if (xyOk) begin
                    oField  <= xyF;
                    oVBLANK <= xyV;
                    phase   <= 2'd0;
                    if (xyV) begin
                        lineRst <= 1'b1;
                    end
                    if (!xyH && !xyV) begin
                        state  <= ST_ACTIVE;
                        pixCnt <= '0;
                        if (lineRst) begin
                            oLine   <= '0;
                            lineRst <= 1'b0;
                        end else begin
                            oLine <= oLine + 1'b1;
                        end
                    end else begin
                        state <= ST_BLANK;
                    end
                end else begin
                    oCodeErr <= 1'b1;
                end
            end else if (state == ST_ACTIVE) begin
                if (isFF) begin
                    state <= ST_BLANK;
                    phase <= 2'd0;
                end else begin
                    phase <= phase + 2'd1;
                    unique case (phase)
                        2'd0: cbReg <= iTD_DATA;
                        2'd1: y0Reg <= iTD_DATA;
                        2'd2: begin
                            crReg <= iTD_DATA;
                            if (canEmit) begin
                                oY     <= y0Reg;
                                oCb    <= cbReg;
                                oCr    <= iTD_DATA;
                                oX     <= pixCnt[9:0];
                                oDVAL  <= 1'b1;
                                pixCnt <= pixCnt + 11'd1;
                            end
                        end
                        2'd3: begin
                            if (canEmit) begin
                                oY     <= iTD_DATA;
                                oCb    <= cbReg;
                                oCr    <= crReg;
                                oX     <= pixCnt[9:0];
                                oDVAL  <= 1'b1;
                                pixCnt <= pixCnt + 11'd1;
                            end
                            // Line is full once this pair lands; drop the rest.
                            if (pixCnt + 11'd1 >= PIX_MAX) begin
                                state <= ST_BLANK;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_itu656_ycbcr_decoder.sv
// Directed bench for the BT.656 decoder: timing codes, pixel pairs,
// full line, blanking, protection errors and aborts.
module tb_itu656_ycbcr_decoder;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b1;
    logic [7:0] iTD_DATA = 8'h00;
    logic [7:0] oY, oCb, oCr;
    logic       oDVAL;
    logic [9:0] oX;
    logic [9:0] oLine;
    logic       oField, oVBLANK, oCodeErr;

    int nChecks = 0;
    int nErrors = 0;
    int dvalCount;

    itu656_ycbcr_decoder #(.H_ACTIVE(720), .LINE_W(10)) dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iTD_DATA (iTD_DATA),
        .oY       (oY),
        .oCb      (oCb),
        .oCr      (oCr),
        .oDVAL    (oDVAL),
        .oX       (oX),
        .oLine    (oLine),
        .oField   (oField),
        .oVBLANK  (oVBLANK),
        .oCodeErr (oCodeErr)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte is sampled at the next edge; outputs checked 1 ns after it.
    task automatic sendByte(input logic [7:0] b);
        iTD_DATA = b;
        @(posedge iCLK);
        #1;
    endtask

    task automatic sendQuiet(input string tag, input logic [7:0] b);
        sendByte(b);
        chk(tag, 32'(oDVAL), 32'd0);
    endtask

    task automatic sendCode(input logic [7:0] xy);
        sendByte(8'hFF);
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(xy);
    endtask

    task automatic chkPix(input string tag, input logic [7:0] y,
                          input logic [7:0] cb, input logic [7:0] cr,
                          input logic [9:0] x);
        chk({tag, "_dval"}, 32'(oDVAL), 32'd1);
        chk({tag, "_y"},    32'(oY),    32'(y));
        chk({tag, "_cb"},   32'(oCb),   32'(cb));
        chk({tag, "_cr"},   32'(oCr),   32'(cr));
        chk({tag, "_x"},    32'(oX),    32'(x));
    endtask

    initial begin
        logic [7:0] cb, y0, cr, y1;

        #2 iRST_N = 1'b0;
        #1;
        chk("rst_y",     32'(oY),       32'd0);
        chk("rst_dval",  32'(oDVAL),    32'd0);
        chk("rst_x",     32'(oX),       32'd0);
        chk("rst_line",  32'(oLine),    32'd0);
        chk("rst_field", 32'(oField),   32'd0);
        chk("rst_vbl",   32'(oVBLANK),  32'd0);
        chk("rst_err",   32'(oCodeErr), 32'd0);
        @(posedge iCLK);
        #1 iRST_N = 1'b1;

        // Single pair
        sendCode(8'h80);
        chk("sp_xy_dval", 32'(oDVAL), 32'd0);
        sendQuiet("sp_cb", 8'h60);
        sendQuiet("sp_y0", 8'h10);
        sendByte(8'hA0);
        chkPix("sp_p0", 8'h10, 8'h60, 8'hA0, 10'd0);
        chk("sp_line",  32'(oLine),   32'd0);
        chk("sp_field", 32'(oField),  32'd0);
        chk("sp_vbl",   32'(oVBLANK), 32'd0);
        sendByte(8'h20);
        chkPix("sp_p1", 8'h20, 8'h60, 8'hA0, 10'd1);
        sendQuiet("sp_s6", 8'h33);
        chk("sp_hold_y", 32'(oY), 32'h20);
        chk("sp_hold_x", 32'(oX), 32'd1);
        sendQuiet("sp_s7", 8'h44);

        // Mid-line async reset
        sendCode(8'h80);
        sendByte(8'h60);
        sendByte(8'h10);
        sendByte(8'hA0);
        chkPix("ml_p0", 8'h10, 8'h60, 8'hA0, 10'd0);
        chk("ml_line", 32'(oLine), 32'd1);
        #2 iRST_N = 1'b0;
        #1;
        chk("mr_y",    32'(oY),     32'd0);
        chk("mr_cb",   32'(oCb),    32'd0);
        chk("mr_cr",   32'(oCr),    32'd0);
        chk("mr_dval", 32'(oDVAL),  32'd0);
        chk("mr_line", 32'(oLine),  32'd0);
        iTD_DATA = 8'h00;
        @(posedge iCLK);
        #1 iRST_N = 1'b1;
        sendQuiet("mr_d0", 8'h80);
        sendQuiet("mr_d1", 8'h60);
        sendQuiet("mr_d2", 8'h10);
        sendQuiet("mr_d3", 8'hA0);
        sendQuiet("mr_d4", 8'h20);

        // Full line
        dvalCount = 0;
        sendCode(8'h80);
        chk("fl_line", 32'(oLine), 32'd0);
        for (int i = 0; i < 360; i++) begin
            cb = 8'(8'h40 + (i % 100));
            cr = 8'(8'h80 + (i % 100));
            y0 = 8'(8'h10 + ((2 * i) % 200));
            y1 = 8'(8'h10 + ((2 * i + 1) % 200));
            sendByte(cb);
            dvalCount += int'(oDVAL);
            sendByte(y0);
            dvalCount += int'(oDVAL);
            sendByte(cr);
            dvalCount += int'(oDVAL);
            chkPix("fl_p0", y0, cb, cr, 10'(2 * i));
            sendByte(y1);
            dvalCount += int'(oDVAL);
            chkPix("fl_p1", y1, cb, cr, 10'(2 * i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            sendByte(8'h11);
            dvalCount += int'(oDVAL);
        end
        chk("fl_hold_x", 32'(oX), 32'd719);
        sendCode(8'h9D);
        dvalCount += int'(oDVAL);
        chk("fl_count", 32'(dvalCount), 32'd720);
        chk("fl_eav_vbl", 32'(oVBLANK), 32'd0);
        chk("fl_eav_err", 32'(oCodeErr), 32'd0);
        sendCode(8'h80);
        chk("fl2_line", 32'(oLine), 32'd1);
        sendByte(8'h61);
        sendByte(8'h12);
        sendByte(8'hA1);
        chkPix("fl2_p0", 8'h12, 8'h61, 8'hA1, 10'd0);

        // Vertical blanking and field change
        sendCode(8'hAB);
        chk("vb_vbl", 32'(oVBLANK), 32'd1);
        chk("vb_field", 32'(oField), 32'd0);
        sendQuiet("vb_d0", 8'h60);
        sendQuiet("vb_d1", 8'h10);
        sendQuiet("vb_d2", 8'hA0);
        sendQuiet("vb_d3", 8'h20);
        sendCode(8'hC7);
        chk("f1_field", 32'(oField),  32'd1);
        chk("f1_vbl",   32'(oVBLANK), 32'd0);
        chk("f1_line",  32'(oLine),   32'd0);
        sendByte(8'h62);
        sendByte(8'h14);
        sendByte(8'hA2);
        chkPix("f1_p0", 8'h14, 8'h62, 8'hA2, 10'd0);
        sendByte(8'h24);
        chkPix("f1_p1", 8'h24, 8'h62, 8'hA2, 10'd1);

        // Protection error
        sendCode(8'h81);
        chk("pe_err",   32'(oCodeErr), 32'd1);
        chk("pe_field", 32'(oField),   32'd1);
        chk("pe_vbl",   32'(oVBLANK),  32'd0);
        sendQuiet("pe_d0", 8'h60);
        chk("pe_err_clr", 32'(oCodeErr), 32'd0);
        sendQuiet("pe_d1", 8'h10);
        sendQuiet("pe_d2", 8'hA0);
        sendQuiet("pe_d3", 8'h20);
        chk("pe_line", 32'(oLine), 32'd0);

        // FF abort mid-quad
        sendCode(8'h80);
        chk("ab_line", 32'(oLine), 32'd1);
        sendQuiet("ab_cb", 8'h60);
        sendQuiet("ab_y0", 8'h10);
        sendQuiet("ab_ff", 8'hFF);
        sendQuiet("ab_d0", 8'h40);
        sendQuiet("ab_d1", 8'h50);
        sendQuiet("ab_d2", 8'h30);
        sendQuiet("ab_d3", 8'h70);
        sendCode(8'h80);
        sendByte(8'h65);
        sendByte(8'h15);
        sendByte(8'hA5);
        chkPix("ab_p0", 8'h15, 8'h65, 8'hA5, 10'd0);
        chk("ab_line2", 32'(oLine), 32'd2);
        sendByte(8'hFF);
        chk("ab_y1ff", 32'(oDVAL), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/itu656_ycbcr_decoder.md
# itu656_ycbcr_decoder

Decodes an 8-bit ITU-R BT.656 (4:2:2) byte stream from the TV decoder into one 8-bit Y/Cb/Cr triple per pixel, with chroma replicated across each pixel pair. It sits directly upstream of the YCbCr-to-RGB converter and drives that stage's `iY`, `iCb`, `iCr` and `iDVAL` inputs. It also reports pixel/line position, field, vertical blanking and timing-code errors.

## Interface
- `H_ACTIVE`, default 720: maximum pixels emitted per active line.
- `LINE_W`, default 10: width of the line counter.
- `iCLK` input 1: byte clock (27 MHz); one stream byte per cycle.
- `iRST_N` input 1: reset, asynchronous, active-low.
- `iTD_DATA` input 8: BT.656 stream byte.
- `oY` output 8: luma of the current pixel.
- `oCb` output 8: Cb of the pixel pair.
- `oCr` output 8: Cr of the pixel pair.
- `oDVAL` output 1: `oY`, `oCb`, `oCr` and `oX` are valid this cycle.
- `oX` output 10: pixel index within the line (0..`H_ACTIVE`-1), valid with `oDVAL`.
- `oLine` output `LINE_W`: active line index within the field.
- `oField` output 1: F bit of the last valid timing code.
- `oVBLANK` output 1: V bit of the last valid timing code.
- `oCodeErr` output 1: one-cycle pulse when a preamble is followed by a bad XY byte.

## Operation
- **Preamble window**
  - A 3-byte shift register holds the last three bytes and runs in every state.
  - A timing code is detected when the window holds FF,00,00 (oldest first) and the current byte is XY.
- **XY validation**
  - Bit 7 must be 1.
  - Bits 6/5/4 are F/V/H.
  - Protection bits must satisfy P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
  - On failure: pulse `oCodeErr`, discard the code, leave state, `oField` and `oVBLANK` unchanged.
- **Valid code**: update `oField` and `oVBLANK`.
- **States**
  - BLANK → ACTIVE on a valid SAV (H=0) with V=0.
  - ACTIVE → BLANK on:
    - any valid EAV (H=1);
    - any byte equal to FF;
    - the 2-bit phase wrapping after `H_ACTIVE` pixels have been emitted.
  - A SAV with V=1 leaves the block in BLANK.
- **ACTIVE byte phase**: cycles Cb, Y0, Cr, Y1, starting with the byte after the SAV XY byte.
  - pixel0 = (Y0, Cb, Cr), emitted after Cr is captured.
  - pixel1 = (Y1, Cb, Cr), emitted after Y1 is captured.
- **Abort/exit**: a partial quad pending on exit is discarded; a pair already started is never completed later.
- **`oX`**: 0 at each active SAV; increments per emitted pixel; stops at `H_ACTIVE`-1. Excess bytes before the EAV produce no pixels.
- **`oLine`**
  - Cleared to 0 at the first active SAV following any valid code with V=1.
  - Otherwise increments by 1 at each subsequent active SAV.
  - Wraps modulo 2^`LINE_W`.
- **Reset** (asynchronous, any time, including mid-line):
  - Clears the window to 00, so no false preamble.
  - Clears the phase and all counters; state = BLANK.
  - All outputs 0.

## Timing
- All outputs are registered.
- Let the SAV XY byte be present in cycle s. Then:
  - Cb is in s+1, Y0 in s+2, Cr in s+3, Y1 in s+4.
  - `oDVAL`=1 in cycles s+4 (pixel0) and s+5 (pixel1), and 0 in s+6 and s+7.
  - The pattern repeats every 4 cycles.
- Latency: 1 cycle from the Cr byte to pixel0, and 1 cycle from the Y1 byte to pixel1.
- `oCodeErr`, `oField` and `oVBLANK` update in the cycle after the XY byte.
- State changes on XY take effect for the next byte.
- FF abort: the FF byte itself is never treated as data. If the FF is the Y1 byte, pixel1 is not emitted.
- `oY`, `oCb`, `oCr` and `oX` hold their last values while `oDVAL`=0.

## Test plan
- **Reset:** assert `iRST_N`=0 mid-line → all outputs 0 immediately (asynchronous). Release, then feed stream bytes 0x80,0x60,0x10,0xA0,0x20 (no FF,00,00 preamble) → no `oDVAL`.
- **Single pair:** FF,00,00,0x80 then 0x60,0x10,0xA0,0x20 → (Y,Cb,Cr,X) = (0x10,0x60,0xA0,0) in s+4, then (0x20,0x60,0xA0,1) in s+5, with `oLine`=0, `oField`=0, `oVBLANK`=0.
- **Full line:** SAV 0x80, 1440 data bytes, 4 extra non-FF bytes, EAV FF,00,00,0x9D → exactly 720 `oDVAL` pulses, `oX` 0..719, extra bytes ignored. A second line with SAV 0x80 gives `oLine`=1.
- **Blanking/field:** SAV 0xAB (V=1) followed by data → no `oDVAL`, `oVBLANK`=1. Then SAV 0xC7 (F=1, V=0) → `oField`=1, `oLine`=0, pixels emitted.
- **Protection error:** FF,00,00,0x81 → `oCodeErr` high for exactly 1 cycle; following data gives no `oDVAL`; `oField`/`oVBLANK` unchanged.
- **Abort:** after SAV 0x80, send 0x60,0x10,0xFF → no pixel emitted, state BLANK. Subsequent 0x40,0x50 gives no `oDVAL` until the next valid SAV.
